// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the shared-subtractor divide-by-constant arbiter.
package div_arb_pkg;

   localparam int W_DEF       = 4;
   localparam int DIVISOR_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SUB  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/div_arb_sub_step.sv
// One restoring-division step against a constant: compare and subtract.
module sub_step #(
   parameter int W       = 4,
   parameter int DIVISOR = 3
) (
   input  logic [W-1:0] acc,
   output logic         ge,
   output logic [W-1:0] nxt
);

   localparam logic [W-1:0] D = W'(DIVISOR);

   assign ge  = (acc >= D);
   assign nxt = acc - D;

endmodule

// File: rtl/div_arb.sv
// Two-requester divide-by-constant unit: round-robin grant, then one subtraction
// per clock until the remainder drops below the divisor.
module div_arb
   import div_arb_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int DIVISOR = DIVISOR_DEF
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         req0,
   input  logic [W-1:0] i0,
   input  logic         req1,
   input  logic [W-1:0] i1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         vld,
   output logic         vld_id,
   output logic [1:0]   dbg_state
);

   if (DIVISOR < 1 || DIVISOR > (2**W) - 1) begin : g_bad_divisor
      $error("div_arb: DIVISOR must lie in 1..2^W-1");
   end

   // Handshake: a requester holds reqN and iN stable until it sees gntN (a
   // one-cycle pulse marking the capture edge) and drops reqN in that cycle.
   // Requests are only sampled in IDLE; a losing requester simply keeps waiting.
   state_e       state_q;
   logic [W-1:0] acc_q, cnt_q, q_q, r_q;
   logic         owner_q, last_q, gnt0_q, gnt1_q, busy_q, vld_q, vld_id_q;
   logic         win_d, ge;
   logic [W-1:0] nxt;

   assign win_d = (req0 && req1) ? ~last_q : req1;

   sub_step #(.W(W), .DIVISOR(DIVISOR)) u_sub_step (
      .acc (acc_q),
      .ge  (ge),
      .nxt (nxt)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         q_q      <= '0;
         r_q      <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         busy_q   <= 1'b0;
         vld_q    <= 1'b0;
         vld_id_q <= 1'b0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         vld_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  acc_q   <= win_d ? i1 : i0;
                  cnt_q   <= '0;
                  owner_q <= win_d;
                  last_q  <= win_d;
                  gnt0_q  <= ~win_d;
                  gnt1_q  <= win_d;
                  busy_q  <= 1'b1;
                  state_q <= SUB;
               end
            end
            SUB: begin
               if (ge) begin
                  acc_q <= nxt;
                  cnt_q <= cnt_q + W'(1);
               end else begin
                  q_q      <= cnt_q;
                  r_q      <= acc_q;
                  vld_id_q <= owner_q;
                  vld_q    <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign busy      = busy_q;
   assign q         = q_q;
   assign r         = r_q;
   assign vld       = vld_q;
   assign vld_id    = vld_id_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_div_arb.sv
// Bench for div_arb: directed requests with hand-computed results, scoreboard
// queues for grants and results, checked by a free-running monitor.
module tb_div_arb;

   localparam int W  = 4;
   localparam int EW = 17;

   logic         clk, rst_b;
   logic         req0, req1;
   logic [W-1:0] i0, i1;
   logic         gnt0, gnt1, busy, vld, vld_id;
   logic [W-1:0] q, r;
   logic [1:0]   dbg_state;

   int n_chk, n_fail;
   int cyc, cap_cyc;
   bit in_reset, after_vld;
   logic [W-1:0] held_q, held_r;
   logic         held_id;

   // {latency[7:0], id, q[3:0], r[3:0]}
   logic [EW-1:0] exp_q[$];
   logic          exp_gnt_q[$];

   div_arb #(.W(4), .DIVISOR(3)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req0      (req0),
      .i0        (i0),
      .req1      (req1),
      .i1        (i1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .busy      (busy),
      .q         (q),
      .r         (r),
      .vld       (vld),
      .vld_id    (vld_id),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input int lat, input logic id,
                                        input logic [W-1:0] eq, input logic [W-1:0] er);
      logic [7:0] l8;
      l8 = 8'(lat);
      return {l8, id, eq, er};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_q"}, 32'(q), 0);
      check({tag, "_r"}, 32'(r), 0);
      check({tag, "_vld"}, 32'(vld), 0);
      check({tag, "_vld_id"}, 32'(vld_id), 0);
      check({tag, "_gnt0"}, 32'(gnt0), 0);
      check({tag, "_gnt1"}, 32'(gnt1), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_state"}, 32'(dbg_state), 0);
   endtask

   task automatic clear_model();
      held_q    = '0;
      held_r    = '0;
      held_id   = 1'b0;
      after_vld = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [EW-1:0] e;
      logic          eg;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_b && !in_reset) begin
            if (gnt0 || gnt1) begin
               check("gnt_onehot", 32'(gnt0 & gnt1), 0);
               if (exp_gnt_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_gnt: got gnt0=%0b gnt1=%0b expected none", gnt0, gnt1);
               end else begin
                  eg = exp_gnt_q.pop_front();
                  check("gnt_id", 32'(gnt1), 32'(eg));
               end
               check("busy_at_gnt", 32'(busy), 1);
               check("hold_q", 32'(q), 32'(held_q));
               check("hold_r", 32'(r), 32'(held_r));
               check("hold_id", 32'(vld_id), 32'(held_id));
               cap_cyc = cyc;
            end
            if (vld) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_vld: got q=%0d r=%0d expected no result", q, r);
               end else begin
                  e = exp_q.pop_front();
                  check("res_q", 32'(q), 32'(e[7:4]));
                  check("res_r", 32'(r), 32'(e[3:0]));
                  check("res_id", 32'(vld_id), 32'(e[8]));
                  check("latency", 32'(cyc - cap_cyc), 32'(e[16:9]));
                  held_q  = e[7:4];
                  held_r  = e[3:0];
                  held_id = e[8];
               end
               check("busy_at_vld", 32'(busy), 1);
               after_vld = 1'b1;
            end else if (after_vld) begin
               check("busy_after_done", 32'(busy), 0);
               after_vld = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_gnt_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL %s_timeout: got %0d results pending expected 0", tag, exp_q.size());
         exp_q.delete();
         exp_gnt_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic req_one(input logic id, input logic [W-1:0] val,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
      int n;
      exp_gnt_q.push_back(id);
      exp_q.push_back(mk(int'(eq) + 1, id, eq, er));
      if (id) begin req1 = 1'b1; i1 = val; end
      else    begin req0 = 1'b1; i0 = val; end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(id ? gnt1 : gnt0) && n < 50);
      req0 = 1'b0;
      req1 = 1'b0;
      wait_drain("req_one");
   endtask

   task automatic apply_reset();
      in_reset = 1'b1;
      rst_b = 1'b0;
      req0 = 1'b0; req1 = 1'b0; i0 = '0; i1 = '0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      clear_model();
      in_reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, g;
      n_chk = 0; n_fail = 0; cyc = 0; cap_cyc = 0;
      clear_model();
      apply_reset();
      check_all_zero("reset");

      // single requesters
      req_one(1'b0, 4'd9, 4'd3, 4'd0);
      req_one(1'b1, 4'd14, 4'd4, 4'd2);

      // contention from reset, both held: grants 0,1,0,1
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         exp_gnt_q.push_back(1'b0);
         exp_q.push_back(mk(3, 1'b0, 4'd2, 4'd1));
         exp_gnt_q.push_back(1'b1);
         exp_q.push_back(mk(2, 1'b1, 4'd1, 4'd2));
      end
      i0 = 4'd7; i1 = 4'd5; req0 = 1'b1; req1 = 1'b1;
      n = 0; g = 0;
      while (g < 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (gnt0 || gnt1) g++;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_drain("contend");

      // boundaries, then exhaustive sweep with alternating requesters
      req_one(1'b0, 4'd0, 4'd0, 4'd0);
      req_one(1'b0, 4'd15, 4'd5, 4'd0);
      for (int v = 0; v < 16; v++)
         req_one(v[0], 4'(v), 4'(v / 3), 4'(v % 3));

      // reset in the middle of a long division
      exp_gnt_q.push_back(1'b0);
      req0 = 1'b1; i0 = 4'd15;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!gnt0 && n < 50);
      req0 = 1'b0;
      @(negedge clk);
      #2;
      in_reset = 1'b1;
      rst_b = 1'b0;
      #1;
      check_all_zero("async_rst");
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      clear_model();
      in_reset = 1'b0;

      // pointer is back to favouring requester 0
      exp_gnt_q.push_back(1'b0);
      exp_q.push_back(mk(3, 1'b0, 4'd2, 4'd1));
      exp_gnt_q.push_back(1'b1);
      exp_q.push_back(mk(2, 1'b1, 4'd1, 4'd2));
      i0 = 4'd7; i1 = 4'd5; req0 = 1'b1; req1 = 1'b1;
      n = 0;
      while ((req0 || req1) && n < 100) begin
         @(negedge clk);
         n++;
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_drain("post_reset");
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
